regfile_mp: RTL and testbench

//  Multi-port GPR file with write-side scoreboard for the dual-issue Saratoga core. Provides
//  NUM_RD read ports, NUM_WR write ports and same-cycle write->read bypass. A per-register

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, writeback and issue/scoreboard bus of the multi-port register file.
interface regfile_mp_if #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2
);
    localparam int AW = $clog2(REG_COUNT);
    logic [NUM_RD-1:0]      rd_en;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_ready;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   iss_ok;
    logic                   flush;
    logic [AW:0]            busy_cnt;
    modport master(
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_ready, iss_ok, busy_cnt
    );
    modport slave(
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_ready, iss_ok, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with write->read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    logic [XLEN-1:0]        regs [REG_COUNT];
    logic [REG_COUNT-1:0]   busy, busy_nxt, wmask;
    logic [AW:0]            cnt_nxt;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_ready;
    logic                   iss_nz;

    always_comb begin
        wmask = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (bus.wr_en[j]) wmask[bus.wr_addr[j*AW +: AW]] = 1'b1;
        wmask[0] = 1'b0;
    end

    assign iss_nz     = bus.iss_addr != '0;
    assign bus.iss_ok = bus.iss_en & ~bus.flush &
                        (~iss_nz | ~busy[bus.iss_addr] | wmask[bus.iss_addr]);

    // an accepted issue overrides a same-cycle writeback clear
    always_comb begin
        busy_nxt = bus.flush ? '0 : busy & ~wmask;
        if (bus.iss_ok && iss_nz) busy_nxt[bus.iss_addr] = 1'b1;
        cnt_nxt = '0;
        for (int r = 0; r < REG_COUNT; r++) cnt_nxt += (AW+1)'(busy_nxt[r]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
            busy         <= '0;
            bus.busy_cnt <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            busy         <= busy_nxt;
            bus.busy_cnt <= cnt_nxt;
        end

    // later write ports overwrite earlier ones, giving highest-index bypass priority
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        for (int i = 0; i < NUM_RD; i++)
            if (bus.rd_en[i] && bus.rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[bus.rd_addr[i*AW +: AW]];
                rd_ready[i]             = ~busy[bus.rd_addr[i*AW +: AW]];
                for (int j = 0; j < NUM_WR; j++)
                    if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW]) begin
                        rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                        rd_ready[i]             = 1'b1;
                    end
            end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_ready = rd_ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int RC   = 32;
    localparam int NR   = 4;
    localparam int NW   = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW)) bus();
    regfile_mp #(.XLEN(XLEN), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [XLEN-1:0] mreg [RC];
    bit              mbusy [RC];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < RC; r++) begin
            mreg[r]  = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    task automatic clr();
        bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        bus.wr_en[p] = 1'b1;
        bus.wr_addr[p*AW +: AW] = AW'(a);
        bus.wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        bus.iss_en = 1'b1;
        bus.iss_addr = AW'(a);
    endtask

    // called at negedge with inputs applied; checks comb outputs, steps model, checks busy_cnt
    task automatic cycle();
        logic [AW-1:0]   a, ia;
        logic [XLEN-1:0] d;
        bit rdy, ok, wrote;
        int cnt;
        #1;
        for (int p = 0; p < NR; p++) begin
            a = bus.rd_addr[p*AW +: AW];
            d = '0;
            rdy = 1'b1;
            if (bus.rd_en[p] && a != 0) begin
                d = mreg[a];
                rdy = !mbusy[a];
                for (int j = 0; j < NW; j++)
                    if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
                        d = bus.wr_data[j*XLEN +: XLEN];
                        rdy = 1'b1;
                    end
            end
            check($sformatf("rd_data%0d x%0d", p, a), 64'(bus.rd_data[p*XLEN +: XLEN]), 64'(d));
            check($sformatf("rd_ready%0d x%0d", p, a), 64'(bus.rd_ready[p]), 64'(rdy));
        end
        ia = bus.iss_addr;
        wrote = 1'b0;
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ia) wrote = 1'b1;
        ok = bus.iss_en && !bus.flush && (ia == 0 || !mbusy[ia] || wrote);
        check("iss_ok", 64'(bus.iss_ok), 64'(ok));
        @(posedge clk);
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != 0) begin
                mreg[bus.wr_addr[j*AW +: AW]]  = bus.wr_data[j*XLEN +: XLEN];
                mbusy[bus.wr_addr[j*AW +: AW]] = 1'b0;
            end
        if (bus.flush) for (int r = 0; r < RC; r++) mbusy[r] = 1'b0;
        if (ok && ia != 0) mbusy[ia] = 1'b1;
        @(negedge clk);
        cnt = 0;
        for (int r = 0; r < RC; r++) cnt += int'(mbusy[r]);
        check("busy_cnt", 64'(bus.busy_cnt), 64'(cnt));
    endtask

    task automatic read_all();
        for (int r = 0; r < RC; r += NR) begin
            clr();
            for (int p = 0; p < NR; p++) set_rd(p, r + p);
            cycle();
        end
    endtask

    initial begin
        clr();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("busy_cnt_in_reset", 64'(bus.busy_cnt), 64'd0);
        rst_n = 1'b1;
        read_all();
        // bypass then stored value
        clr(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); cycle();
        clr(); set_rd(0, 5); cycle();
        // same-address write on both ports, highest index wins
        clr(); set_wr(0, 7, 32'd1); set_wr(1, 7, 32'd2); set_rd(1, 7); cycle();
        clr(); set_rd(1, 7); cycle();
        // scoreboard on x3
        clr(); iss(3); set_rd(0, 3); cycle();
        clr(); iss(3); set_rd(0, 3); cycle();
        clr(); set_wr(1, 3, 32'h55); set_rd(2, 3); cycle();
        clr(); set_rd(0, 3); cycle();
        // issue and writeback of x9 together
        clr(); iss(9); set_wr(0, 9, 32'h1234_5678); cycle();
        clr(); set_rd(0, 9); cycle();
        // writes to x0 are discarded
        clr(); set_wr(1, 0, 32'hFFFF_FFFF); iss(0); cycle();
        clr(); set_rd(3, 0); cycle();
        // busy x1..x4 then flush with a competing issue
        for (int a = 1; a <= 4; a++) begin
            clr(); iss(a); cycle();
        end
        clr(); bus.flush = 1'b1; iss(6); set_wr(0, 2, 32'hABCD); cycle();
        clr(); for (int p = 0; p < NR; p++) set_rd(p, p + 1); cycle();
        // randomized traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 3000; n++) begin
            clr();
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 3) != 0)
                    set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, RC-1) : $urandom_range(0, 7));
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) != 0)
                    set_wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, RC-1) : $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 1) != 0)
                iss(($urandom_range(0, 3) == 0) ? $urandom_range(0, RC-1) : $urandom_range(0, 7));
            bus.flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        // asynchronous reset in the middle of a write cycle
        clr(); set_wr(0, 10, 32'hCAFE); set_wr(1, 11, 32'hF00D); iss(12);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("busy_cnt_async_rst", 64'(bus.busy_cnt), 64'd0);
        @(posedge clk);
        @(negedge clk);
        clr();
        rst_n = 1'b1;
        read_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
